// File: rtl/mdu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_defs (package)
//  Description : Shared MDU operation encodings and default latencies for the
//                E-stage multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_defs;

    // Codes 9..15 are unused and decode as MDU_NONE.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int c_mult_cycles_default = 5;
    localparam int c_div_cycles_default  = 10;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational 64-bit product and quotient/remainder generator.
//                Signed division is done on magnitudes and the signs are
//                re-applied, so 0x80000000 / -1 naturally yields 0x80000000
//                with remainder 0. A zero divisor is replaced by 1 so that no
//                undefined value is produced; the flag tells the caller to
//                discard the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_defs::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_b_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Full-width products; operands are extended to 64 bits before multiplying.
    assign w_prod_s = 64'($signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b}));
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_signed_div = (i_op == MDU_DIV);
    assign w_is_div     = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    assign w_mag_a      = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_mag_b      = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_b_zero     = (i_b == 32'd0);
    assign w_divisor    = w_b_zero ? 32'd1 : w_mag_b;
    assign w_q_mag      = w_mag_a / w_divisor;
    assign w_r_mag      = w_mag_a % w_divisor;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    assign o_div_by_zero = w_is_div & w_b_zero;

    // Select the HI/LO pair for the requested operation.
    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        case (i_op)
            MDU_MULT:          {o_hi, o_lo} = w_prod_s;
            MDU_MULTU:         {o_hi, o_lo} = w_prod_u;
            MDU_DIV, MDU_DIVU: begin
                o_hi = w_rem;
                o_lo = w_quot;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : E-stage multiply/divide sequencer. Holds HI/LO, captures a
//                pending result when a mult/div is accepted, counts the fixed
//                latency and commits the pending result as busy drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles_default,
    parameter int DIV_CYCLES  = c_div_cycles_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        Req,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDU_result,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_we;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_idle_ok;
    logic [31:0]        w_arith_hi;
    logic [31:0]        w_arith_lo;
    logic               w_div_by_zero;

    mdu_arith u_arith (
        .i_op          (MDU_op),
        .i_a           (rs_data),
        .i_b           (rt_data),
        .o_hi          (w_arith_hi),
        .o_lo          (w_arith_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_is_mul  = (MDU_op == MDU_MULT) || (MDU_op == MDU_MULTU);
    assign w_is_div  = (MDU_op == MDU_DIV)  || (MDU_op == MDU_DIVU);
    // Nothing changes state while flushed or while an op is in flight.
    assign w_idle_ok = ~Req & ~r_busy;
    assign start     = (w_is_mul | w_is_div) & w_idle_ok;

    assign busy   = r_busy;
    assign HI_out = r_hi;
    assign LO_out = r_lo;

    // Move-from path always reads the committed registers.
    always_comb begin
        MDU_result = 32'd0;
        case (MDU_op)
            MDU_MFHI: MDU_result = r_hi;
            MDU_MFLO: MDU_result = r_lo;
            default:  ;
        endcase
    end

    // Accept, count down, commit pending result, and handle MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            if (start) begin
                r_pend_hi <= w_arith_hi;
                r_pend_lo <= w_arith_lo;
                r_pend_we <= ~w_div_by_zero;
                r_count   <= w_is_div ? c_div_load : c_mult_load;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_count <= r_count - c_cnt_one;
                if (r_count == c_cnt_one) begin
                    r_busy <= 1'b0;
                    if (r_pend_we) begin
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
                    end
                end
            end

            // Only reachable when idle, so never collides with a commit.
            if (w_idle_ok && (MDU_op == MDU_MTHI)) begin
                r_hi <= rs_data;
            end
            if (w_idle_ok && (MDU_op == MDU_MTLO)) begin
                r_lo <= rs_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Self-checking bench for mdu_sequencer: directed vector table,
//                hand-written timing sequences and randomized traffic against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;
    import mdu_defs::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDU_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        Req;
    logic        start;
    logic        busy;
    logic [31:0] MDU_result;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .MDU_op     (MDU_op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .Req        (Req),
        .start      (start),
        .busy       (busy),
        .MDU_result (MDU_result),
        .HI_out     (HI_out),
        .LO_out     (LO_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    bit          m_pend_we;
    int          m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a mult/div, straight from the arithmetic rules.
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output bit we, output logic [31:0] hi, output logic [31:0] lo,
                                     output int n);
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        we = 1'b1; hi = 0; lo = 0; n = 0;
        sa = int'(a);
        sb = int'(b);
        case (op)
            4'd1: begin ps = longint'(sa) * longint'(sb); {hi, lo} = ps; n = MC; end
            4'd2: begin pu = {32'd0, a} * {32'd0, b}; {hi, lo} = pu; n = MC; end
            4'd3: begin
                n = DC;
                if (b == 0) we = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            4'd4: begin
                n = DC;
                if (b == 0) we = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endfunction

    function automatic bit is_md(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd4;
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_pend_we = 0; m_left = 0;
    endtask

    // One clock: drive, check combinational outputs, clock, check registers.
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq,
                         output logic st_seen, output logic [31:0] res_seen);
        logic        exp_start;
        logic [31:0] exp_res;
        bit          we;
        logic [31:0] h, l;
        int          n;
        MDU_op = op; rs_data = a; rt_data = b; Req = rq;
        #1;
        exp_start = is_md(op) && !rq && m_left == 0;
        exp_res   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        st_seen   = start;
        res_seen  = MDU_result;
        check("start", {31'd0, start}, {31'd0, exp_start});
        check("mdu_result", MDU_result, exp_res);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_we) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end else if (!rq) begin
            if (is_md(op)) begin
                model_op(op, a, b, we, h, l, n);
                m_pend_we = we; m_pend_hi = h; m_pend_lo = l; m_left = n;
            end else if (op == 4'd7) m_hi = a;
            else if (op == 4'd8) m_lo = a;
        end
        #1;
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("hi", HI_out, m_hi);
        check("lo", LO_out, m_lo);
    endtask

    task automatic do_reset();
        MDU_op = 4'd0; rs_data = 0; rt_data = 0; Req = 0; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI_out, 32'd0);
        check("rst_lo", LO_out, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_result", MDU_result, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t        vecs[9];
    logic        st;
    logic [31:0] rs;
    int          lat;

    initial begin
        vecs[0] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{4'd4, 32'd7,         32'd0,         32'h1111_1111, 32'h2222_2222};
        vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{4'd4, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
        vecs[6] = '{4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[7] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{4'd3, 32'd0,         32'd0,         32'h1111_1111, 32'h2222_2222};

        model_reset();
        do_reset();

        // MULT -2 * 3: busy t+1..t+5, result visible at t+6
        cycle(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, st, rs);
        check("mult_start", {31'd0, st}, 32'd1);
        check("mult_busy_t1", {31'd0, busy}, 32'd1);
        for (int k = 2; k <= MC; k++) begin
            cycle(4'd0, 0, 0, 1'b0, st, rs);
            check("mult_busy_mid", {31'd0, busy}, 32'd1);
        end
        cycle(4'd0, 0, 0, 1'b0, st, rs);
        check("mult_busy_done", {31'd0, busy}, 32'd0);
        check("mult_hi", HI_out, 32'hFFFF_FFFF);
        check("mult_lo", LO_out, 32'hFFFF_FFFA);

        // Vector table: exact latency and final HI/LO
        foreach (vecs[i]) begin
            cycle(4'd7, 32'h1111_1111, 0, 1'b0, st, rs);
            cycle(4'd8, 32'h2222_2222, 0, 1'b0, st, rs);
            cycle(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, st, rs);
            check("vec_start", {31'd0, st}, 32'd1);
            lat = (vecs[i].op == 4'd1 || vecs[i].op == 4'd2) ? MC : DC;
            for (int k = 1; k < lat; k++) cycle(4'd0, 0, 0, 1'b0, st, rs);
            check("vec_busy_last", {31'd0, busy}, 32'd1);
            cycle(4'd0, 0, 0, 1'b0, st, rs);
            check("vec_busy_end", {31'd0, busy}, 32'd0);
            check("vec_hi", HI_out, vecs[i].exp_hi);
            check("vec_lo", LO_out, vecs[i].exp_lo);
        end

        // Req handling
        cycle(4'd7, 32'h1234_5678, 0, 1'b0, st, rs);
        check("mthi_hi", HI_out, 32'h1234_5678);
        cycle(4'd5, 0, 0, 1'b0, st, rs);
        check("mfhi_result", rs, 32'h1234_5678);
        cycle(4'd8, 32'hCAFE_0001, 0, 1'b0, st, rs);
        cycle(4'd8, 32'hAAAA_5555, 0, 1'b1, st, rs);
        check("mtlo_req_lo", LO_out, 32'hCAFE_0001);
        cycle(4'd1, 32'd3, 32'd4, 1'b1, st, rs);
        check("mult_req_start", {31'd0, st}, 32'd0);
        check("mult_req_busy", {31'd0, busy}, 32'd0);

        // Busy guarding: DIV 100/7 at t, MULT at t+3 and MTLO at t+4 ignored
        cycle(4'd7, 32'h5555_0000, 0, 1'b0, st, rs);
        cycle(4'd8, 32'h6666_0000, 0, 1'b0, st, rs);
        cycle(4'd3, 32'd100, 32'd7, 1'b0, st, rs);
        cycle(4'd0, 0, 0, 1'b0, st, rs);
        cycle(4'd0, 0, 0, 1'b0, st, rs);
        cycle(4'd1, 32'd3, 32'd3, 1'b0, st, rs);
        check("guard_mult_start", {31'd0, st}, 32'd0);
        cycle(4'd8, 32'hDEAD_BEEF, 0, 1'b0, st, rs);
        check("guard_mtlo_lo", LO_out, 32'h6666_0000);
        for (int k = 5; k < DC; k++) cycle(4'd0, 0, 0, 1'b0, st, rs);
        check("guard_busy_10", {31'd0, busy}, 32'd1);
        cycle(4'd0, 0, 0, 1'b0, st, rs);
        check("guard_busy_11", {31'd0, busy}, 32'd0);
        check("guard_hi", HI_out, 32'd2);
        check("guard_lo", LO_out, 32'd14);

        // Reset at busy cycle 4 of a MULT discards the pending result
        cycle(4'd1, 32'd5, 32'd5, 1'b0, st, rs);
        for (int k = 1; k < 4; k++) cycle(4'd0, 0, 0, 1'b0, st, rs);
        do_reset();
        for (int k = 0; k < MC + 3; k++) cycle(4'd0, 0, 0, 1'b0, st, rs);
        check("post_reset_hi", HI_out, 32'd0);
        check("post_reset_lo", LO_out, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle(op, a, b, ($urandom_range(0, 4) == 0), st, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
